// File: rtl/count_capture_buf.sv
// Trigger-armed capture buffer for an 8-bit counter stream, drained over a valid/ready port.
// Optional sequence checker (seq_err output) is enabled by defining COUNT_CAP_SEQ_CHECK_EN.
module count_capture_buf #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    input  logic          arm,
    input  logic [DW-1:0] trig_val,
    input  logic [AW:0]   cap_len,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [AW:0]   level,
    output logic          busy,
    output logic          done,
    output logic          overflow,
    output logic          wrap_pulse
`ifdef COUNT_CAP_SEQ_CHECK_EN
    ,
    output logic          seq_err
`endif
);

    localparam logic [AW:0] DepthL = (AW+1)'(DEPTH);
    localparam logic [AW:0] OneL   = (AW+1)'(1);

    typedef enum logic [1:0] {StIdle, StArmed, StCapture, StDone} state_e;

    state_e        state_q, state_d;
    logic [AW:0]   len_q, len_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [AW:0]   level_q, level_d;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic          out_valid_q;
    logic          overflow_q, overflow_d;
    logic          wrap_q;
    logic [DW-1:0] mem_q [DEPTH];

    logic eligible;
    logic push;
    logic pop;
    logic drop;

    // Arm takes priority over any sample presented in the same cycle.
    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        eligible = 1'b0;
        if (arm) begin
            state_d = StArmed;
            len_d   = (cap_len == '0 || cap_len > DepthL) ? DepthL : cap_len;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StArmed, StCapture: begin
                    if (in_valid && (state_q == StCapture || in_data == trig_val)) begin
                        eligible = 1'b1;
                        cnt_d    = cnt_q + OneL;
                        state_d  = (cnt_d == len_q) ? StDone : StCapture;
                    end
                end
                default: state_d = state_q;
            endcase
        end
    end

    // A full buffer still accepts a write when a pop frees the slot in the same cycle.
    always_comb begin
        pop        = out_valid_q && out_ready;
        push       = eligible && (level_q != DepthL || pop);
        drop       = eligible && !push;
        level_d    = level_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d = overflow_q;
        if (arm) begin
            overflow_d = 1'b0;
        end else if (drop) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            len_q       <= DepthL;
            cnt_q       <= '0;
            level_q     <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            overflow_q  <= 1'b0;
            wrap_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            level_q     <= level_d;
            out_valid_q <= (level_d != '0);
            overflow_q  <= overflow_d;
            wrap_q      <= push && (in_data == {DW{1'b1}});
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

`ifdef COUNT_CAP_SEQ_CHECK_EN
    logic [DW-1:0] last_q;
    logic          have_last_q;
    logic          seq_err_q;

    // Drops do not update last_q, so the next write after a drop is flagged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q      <= '0;
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (arm) begin
            have_last_q <= 1'b0;
            seq_err_q   <= 1'b0;
        end else if (push) begin
            if (have_last_q && in_data != last_q + DW'(1)) begin
                seq_err_q <= 1'b1;
            end
            last_q      <= in_data;
            have_last_q <= 1'b1;
        end
    end

    assign seq_err = seq_err_q;
`endif

    assign out_valid  = out_valid_q;
    assign out_data   = mem_q[rd_ptr_q];
    assign level      = level_q;
    assign busy       = (state_q == StArmed) || (state_q == StCapture);
    assign done       = (state_q == StDone);
    assign overflow   = overflow_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: tb/tb_count_capture_buf.sv
// Directed self-checking bench for count_capture_buf; bench-side counter stream drives in_data.
module tb_count_capture_buf;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       arm = 1'b0;
    logic [7:0] trig_val = 8'd0;
    logic [4:0] cap_len = 5'd0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [4:0] level;
    logic       busy;
    logic       done;
    logic       overflow;
    logic       wrap_pulse;
`ifdef COUNT_CAP_SEQ_CHECK_EN
    logic       seq_err;
`endif

    int errors = 0;
    int checks = 0;
    bit stream = 1'b0;
    logic [7:0] got[$];

    count_capture_buf #(.DW(8), .DEPTH(16), .AW(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .arm        (arm),
        .trig_val   (trig_val),
        .cap_len    (cap_len),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .level      (level),
        .busy       (busy),
        .done       (done),
        .overflow   (overflow),
        .wrap_pulse (wrap_pulse)
`ifdef COUNT_CAP_SEQ_CHECK_EN
        ,
        .seq_err    (seq_err)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (stream) in_data = in_data + 8'd1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        arm = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        stream = 1'b0;
        in_data = 8'd0;
        trig_val = 8'd0;
        cap_len = 5'd0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic arm_pulse();
        arm = 1'b1;
        tick();
        arm = 1'b0;
    endtask

    task automatic collect(input int n);
        for (int i = 0; i < n; i++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
        checks++; if (overflow !== 1'b0 || wrap_pulse !== 1'b0) begin errors++; $display("FAIL reset_ovf_wrap: got %b%b expected 00", overflow, wrap_pulse); end
`ifdef COUNT_CAP_SEQ_CHECK_EN
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b expected 0", seq_err); end
`endif
        // Idle ignores samples even when they match the trigger.
        in_valid = 1'b1;
        in_data = 8'd0;
        repeat (3) tick();
        checks++; if (level !== 5'd0) begin errors++; $display("FAIL idle_ignore: level got %0d expected 0", level); end
        in_valid = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        stream = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        trig_val = 8'd10; cap_len = 5'd4;
        got.delete();
        arm_pulse();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: got %b expected 1", busy); end
        for (int i = 0; i < 40 && in_data != 8'd13; i++) collect(1);
        checks++; if (in_data !== 8'd13) begin errors++; $display("FAIL basic_reach13: got %0d expected 13", in_data); end
        collect(1);
        checks++; if (done !== 1'b1 || busy !== 1'b0) begin errors++; $display("FAIL basic_done: got done=%b busy=%b expected 1 0", done, busy); end
        collect(5);
        checks++; if (got.size() !== 4) begin errors++; $display("FAIL basic_count: got %0d expected 4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(10 + i)) begin errors++; $display("FAIL basic_data[%0d]: got %0d expected %0d", i, got[i], 10 + i); end
        end
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: got level=%0d valid=%b expected 0 0", level, out_valid); end
    endtask

    task automatic test_full_capture();
        do_reset();
        stream = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        trig_val = 8'd0; cap_len = 5'd0; in_data = 8'd254;
        arm_pulse();
        repeat (20) tick();
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL full_level: got %0d expected 16", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL full_overflow: got %b expected 0", overflow); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL full_done: got %b expected 1", done); end
        checks++; if (out_valid !== 1'b1 || out_data !== 8'd0) begin errors++; $display("FAIL full_head: got valid=%b data=%0d expected 1 0", out_valid, out_data); end
    endtask

    // Continues from the full buffer left by test_full_capture.
    task automatic test_overflow();
        in_data = 8'd18; trig_val = 8'd20; cap_len = 5'd0;
        arm_pulse();
        checks++; if (overflow !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL ovf_armed: got ovf=%b busy=%b expected 0 1", overflow, busy); end
        tick();
        tick();
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", overflow); end
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
        in_valid = 1'b0; stream = 1'b0; out_ready = 1'b1;
        got.delete();
        collect(20);
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 16", got.size()); end
        for (int i = 0; i < 16 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(i)) begin errors++; $display("FAIL ovf_drain[%0d]: got %0d expected %0d", i, got[i], i); end
        end
        checks++; if (overflow !== 1'b1 || level !== 5'd0) begin errors++; $display("FAIL ovf_sticky: got ovf=%b level=%0d expected 1 0", overflow, level); end
    endtask

    task automatic test_wrap();
        int pulses;
        logic [7:0] pulse_at;
        do_reset();
        stream = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        in_data = 8'd240; trig_val = 8'd250; cap_len = 5'd8;
        got.delete();
        pulses = 0; pulse_at = 8'hxx;
        arm_pulse();
        for (int i = 0; i < 30; i++) begin
            if (out_valid && out_ready) got.push_back(out_data);
            tick();
            if (wrap_pulse === 1'b1) begin pulses++; pulse_at = in_data; end
        end
        checks++; if (pulses !== 1) begin errors++; $display("FAIL wrap_pulses: got %0d expected 1", pulses); end
        checks++; if (pulse_at !== 8'd0) begin errors++; $display("FAIL wrap_timing: next sample at pulse got %0d expected 0", pulse_at); end
        checks++; if (got.size() !== 8) begin errors++; $display("FAIL wrap_count: got %0d expected 8", got.size()); end
        for (int i = 0; i < 8 && i < got.size(); i++) begin
            checks++; if (got[i] !== 8'(250 + i)) begin errors++; $display("FAIL wrap_data[%0d]: got %0d expected %0d", i, got[i], (250 + i) % 256); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        stream = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        trig_val = 8'd0; cap_len = 5'd0; in_data = 8'd254;
        arm_pulse();
        repeat (20) tick();
        in_data = 8'd40; trig_val = 8'd42; cap_len = 5'd2;
        arm_pulse();
        tick();
        checks++; if (level !== 5'd16 || out_data !== 8'd0) begin errors++; $display("FAIL b2b_pre: got level=%0d data=%0d expected 16 0", level, out_data); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        in_valid = 1'b0;
        stream = 1'b0;
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL b2b_level: got %0d expected 16", level); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
        checks++; if (out_data !== 8'd1) begin errors++; $display("FAIL b2b_pop: got %0d expected 1", out_data); end
        out_ready = 1'b1;
        got.delete();
        collect(20);
        checks++; if (got.size() !== 16) begin errors++; $display("FAIL b2b_count: got %0d expected 16", got.size()); end
        checks++; if (got.size() == 16 && (got[0] !== 8'd1 || got[14] !== 8'd15 || got[15] !== 8'd42)) begin
            errors++; $display("FAIL b2b_order: got first=%0d pen=%0d last=%0d expected 1 15 42", got[0], got[14], got[15]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        stream = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        in_data = 8'd0; trig_val = 8'd2; cap_len = 5'd10;
        arm_pulse();
        for (int i = 0; i < 20 && level != 5'd5; i++) tick();
        checks++; if (level !== 5'd5 || busy !== 1'b1) begin errors++; $display("FAIL mid_pre: got level=%0d busy=%b expected 5 1", level, busy); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (level !== 5'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_buf: got level=%0d valid=%b expected 0 0", level, out_valid); end
        checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL mid_reset_fsm: got busy=%b done=%b expected 0 0", busy, done); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        stream = 1'b0;
        in_valid = 1'b0;
    endtask

`ifdef COUNT_CAP_SEQ_CHECK_EN
    task automatic test_seq_err();
        do_reset();
        in_valid = 1'b1; out_ready = 1'b1;
        trig_val = 8'd5; cap_len = 5'd4; in_data = 8'd0;
        arm_pulse();
        in_data = 8'd5; tick();
        in_data = 8'd6; tick();
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_clean: got %b expected 0", seq_err); end
        in_data = 8'd8; tick();
        checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_skip: got %b expected 1", seq_err); end
        in_valid = 1'b0;
        arm_pulse();
        checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL seq_arm_clear: got %b expected 0", seq_err); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_full_capture();
        test_overflow();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
`ifdef COUNT_CAP_SEQ_CHECK_EN
        test_seq_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/count_capture_buf.md
Name: count_capture_buf

Overview:
- Downstream capture stage for the free-running 8-bit cycle counter in the simulation top.
- Waits for a trigger value on the counter stream, then captures a programmed number of consecutive samples into a 16-entry buffer.
- Exposes captured samples over a valid/ready read port so the socket-driven test harness can drain them while the simulation is paused or running.

Parameters:
- DW, 8, sample width in bits.
- DEPTH, 16, buffer entries; must be a power of 2.
- AW, 4, pointer width, log2(DEPTH).

Ports:
- clk  input  1  capture clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  sample present on in_data this cycle.
- in_data  input  DW  counter sample.
- arm  input  1  one-cycle pulse; starts a capture sequence.
- trig_val  input  DW  sample value that starts capture.
- cap_len  input  AW+1  number of samples to capture, 1..DEPTH; 0 is treated as DEPTH.
- out_valid  output  1  buffer non-empty.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  DW  oldest buffered sample, first-word-fall-through.
- level  output  AW+1  current occupancy, 0..DEPTH.
- busy  output  1  state is ARMED or CAPTURE.
- done  output  1  state is DONE.
- overflow  output  1  sticky; a capture-eligible sample was dropped because the buffer was full.
- wrap_pulse  output  1  one-cycle pulse the cycle after an accepted sample equal to all-ones (255).

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE; pointers=0; level=0; out_valid=0; busy=0; done=0; overflow=0; wrap_pulse=0. out_data is don't-care while out_valid=0.
- FSM states: IDLE, ARMED, CAPTURE, DONE.
  - IDLE: inputs are ignored.
  - IDLE -> ARMED on arm. At that point cap_len is latched, overflow is cleared, and the sample counter is cleared. Buffer contents are retained.
  - ARMED: waits for in_valid && in_data==trig_val. The trigger sample itself is captured (counts as sample 1). Next state is CAPTURE, or DONE if latched length is 1.
  - CAPTURE: each in_valid cycle is a capture-eligible sample. After the sample counter reaches the latched length -> DONE. Dropped samples count toward the length.
  - DONE: holds until arm (-> ARMED, same latch and clear actions as from IDLE). The buffer remains readable.
  - arm while ARMED or CAPTURE: restarts at ARMED, relatches cap_len, clears the sample counter. Buffer contents are kept.
- Write: an eligible sample is written when level<DEPTH, or when level==DEPTH and a read occurs in the same cycle (simultaneous read/write on full is accepted).
  - Otherwise the sample is dropped and overflow is set.
  - level is unchanged on simultaneous read and write.
- Read: a pop occurs when out_valid && out_ready. out_valid = (level!=0), registered.
  - A sample written in cycle N is visible at out_data with out_valid=1 in cycle N+1.
  - A read on an empty buffer is ignored.
- Pointers wrap modulo DEPTH. level is AW+1 bits and never exceeds DEPTH.
- wrap_pulse: registered; high for exactly one cycle after a written sample equal to {DW{1'b1}}. Dropped samples do not pulse.
- A reset asserted mid-capture aborts the capture immediately with all state as listed above. No partial state survives.

Optional Feature:
- Macro: COUNT_CAP_SEQ_CHECK_EN.
- Defined:
  - Adds output seq_err (1 bit), reset 0, cleared on arm.
  - seq_err is set sticky if any written sample after the first one in a capture is not equal to (previous written sample + 1) mod 2^DW.
  - A dropped sample breaks the chain; the next written sample is compared against the last written sample + 1, so a drop causes seq_err.
- Not defined: the port and its logic are absent.

Test Plan:
- Reset, then arm with trig_val=10 and cap_len=4, with counter 0..255 streaming and out_ready=1 -> out_data sequence 10, 11, 12, 13; done=1 one cycle after sample 13 is accepted; level returns to 0.
- cap_len=0, trig_val=0, out_ready=0 -> 16 samples 0..15 stored; level=16; overflow=0; done=1.
- cap_len=0, trig_val=0, out_ready=0, then a second arm without draining with trig_val=20 -> the sample at 20 is dropped and overflow=1; draining yields 0..15.
- trig_val=250, cap_len=8, out_ready=1 -> outputs 250..255, 0, 1; wrap_pulse high exactly once, in the cycle after 255 is written.
- level=16 with out_ready=1 and an eligible sample in the same cycle -> level stays 16, overflow stays 0, oldest sample popped.
- rst_n low during CAPTURE at level=5 -> immediately level=0, out_valid=0, busy=0. With COUNT_CAP_SEQ_CHECK_EN, injecting a skipped value (5, 7) during capture -> seq_err=1.
